// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-RAM port between the CPU load/store path
// and a single auxiliary requester. The CPU has priority. A bounded wait
// counter forces the auxiliary request through after MAX_WAIT contended
// cycles, and it stalls the CPU for that one cycle.
// Optional build macro: DMEM_ARB_STATS_EN adds saturating 16-bit counters
// of CPU stall cycles and auxiliary grant cycles.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_stall,
  input  logic              i_aux_req,
  input  logic              i_aux_we,
  input  logic [ADDR_W-1:0] i_aux_addr,
  input  logic [DATA_W-1:0] i_aux_wdata,
  output logic              o_aux_gnt,
  output logic              o_aux_rvalid,
  output logic [DATA_W-1:0] o_aux_rdata,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]       o_stat_stalls,
  output logic [15:0]       o_stat_aux_grants,
`endif
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_aux_rvalid;
  logic [DATA_W-1:0] r_aux_rdata;
  logic              w_aux_gnt;
  logic              w_forced;

  // Grant: auxiliary wins when the CPU is idle or its wait has hit the bound.
  // Gated by reset so nothing reaches the RAM while the core is held.
  always_comb begin
    w_forced  = (r_wait_cnt == LP_MAX);
    w_aux_gnt = ~i_rst & i_aux_req & (~i_cpu_req | w_forced);
  end

  // Memory port mux and CPU-side outputs.
  always_comb begin
    o_aux_gnt   = w_aux_gnt;
    o_cpu_stall = i_cpu_req & w_aux_gnt;
    o_cpu_rdata = i_mem_rdata;
    if (w_aux_gnt) begin
      o_mem_we    = i_aux_we;
      o_mem_addr  = i_aux_addr;
      o_mem_wdata = i_aux_wdata;
    end else begin
      o_mem_we    = ~i_rst & i_cpu_req & i_cpu_we;
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
    end
  end

  // Wait counter: counts contended cycles of a pending auxiliary request and
  // restarts after every grant, so the CPU owns the next MAX_WAIT cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
    end else if (!i_aux_req || w_aux_gnt) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != LP_MAX) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Auxiliary read return: one-cycle valid pulse, data held between reads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_aux_rvalid <= 1'b0;
      r_aux_rdata  <= '0;
    end else begin
      r_aux_rvalid <= w_aux_gnt & ~i_aux_we;
      if (w_aux_gnt && !i_aux_we) begin
        r_aux_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_aux_rvalid = r_aux_rvalid;
  assign o_aux_rdata  = r_aux_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_stat_stalls;
  logic [15:0] r_stat_aux_grants;

  // Saturating event counters for stall and grant cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stat_stalls     <= '0;
      r_stat_aux_grants <= '0;
    end else begin
      if (o_cpu_stall && r_stat_stalls != 16'hFFFF) begin
        r_stat_stalls <= r_stat_stalls + 16'd1;
      end
      if (w_aux_gnt && r_stat_aux_grants != 16'hFFFF) begin
        r_stat_aux_grants <= r_stat_aux_grants + 16'd1;
      end
    end
  end

  assign o_stat_stalls     = r_stat_stalls;
  assign o_stat_aux_grants = r_stat_aux_grants;
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data-memory port of the Gambling_Tec core between the CPU load/store path and one auxiliary requester, such as a display scanner or RNG seeder. The block sits between the datapath's ALUResult/WriteData/MemWrite signals and the data RAM. CPU accesses have priority. A bounded-wait counter guarantees the auxiliary port is served. The CPU is stalled for exactly one cycle whenever the auxiliary port takes the memory.

## Interface
- `ADDR_W`, 32: byte-address width on every port.
- `DATA_W`, 32: data word width.
- `MAX_WAIT`, 4: maximum number of contended cycles an auxiliary request waits before it is forced through. Legal range is ≥1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_req` in 1: CPU access this cycle (MemRead | MemWrite).
- `cpu_we` in 1: CPU write.
- `cpu_addr` in ADDR_W: CPU byte address (ALUResult).
- `cpu_wdata` in DATA_W: CPU store data.
- `cpu_rdata` out DATA_W: combinational read data to CPU (ReadData).
- `cpu_stall` out 1: CPU access not performed; PC and register write must hold.
- `aux_req` in 1: auxiliary request; held high until `aux_gnt`.
- `aux_we` in 1: auxiliary write.
- `aux_addr` in ADDR_W: auxiliary address; stable while `aux_req` is high.
- `aux_wdata` in DATA_W: auxiliary write data; stable while `aux_req` is high.
- `aux_gnt` out 1: auxiliary access performed this cycle.
- `aux_rvalid` out 1: registered read data valid.
- `aux_rdata` out DATA_W: registered read data.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out DATA_W: RAM write data.
- `mem_rdata` in DATA_W: RAM asynchronous read data.

## Operation
- **State:** `wait_cnt` (width clog2(MAX_WAIT+1)), `aux_rvalid` and `aux_rdata` registers.
- **Grant rule:** `aux_gnt = aux_req & (~cpu_req | wait_cnt == MAX_WAIT)`. This rule is combinational and gated off while `rst` is high.
- **`cpu_stall`:** `cpu_req & aux_gnt`.
- **Memory mux:**
  - When `aux_gnt` is high, `mem_*` is driven from `aux_*`.
  - Otherwise `mem_*` is driven from `cpu_*`.
  - `mem_we = aux_gnt ? aux_we : (cpu_req & cpu_we)`.
- **`cpu_rdata`:** always equals `mem_rdata`. It is meaningful only when `cpu_req & ~cpu_stall`.
- **`wait_cnt` update:**
  - Clears to 0 on `aux_gnt` or when `aux_req` is low.
  - Increments on `aux_req & ~aux_gnt`.
  - Never exceeds `MAX_WAIT`.
- **Read return:** on `aux_gnt & ~aux_we`, the next edge sets `aux_rvalid=1` and `aux_rdata=mem_rdata`. Otherwise `aux_rvalid` is 0 next cycle and `aux_rdata` holds its value.
- **Fairness:**
  - After a forced grant, `wait_cnt` restarts at 0, so continuous CPU traffic wins the following `MAX_WAIT` cycles.
  - Back-to-back auxiliary requests with an idle CPU are granted every cycle.
- **Stalled CPU access:** the CPU re-presents the identical access the next cycle, and it is then granted unless the auxiliary port is forced again. A forced grant requires `wait_cnt` to be at `MAX_WAIT`, which cannot happen two cycles in a row.
- **Simultaneous write to the same address:** the auxiliary write lands first (grant cycle) and the CPU write lands one cycle later. The final value is the CPU data.

## Timing
- **CPU path:** zero latency when not stalled. Worst-case stall is 1 cycle per `MAX_WAIT+1` cycles of contention.
- **Auxiliary grant latency:**
  - 0 cycles when the CPU is idle.
  - Exactly `MAX_WAIT` cycles when the CPU requests continuously from the cycle `aux_req` rises.
- **Auxiliary read data:** `aux_rvalid` is asserted one cycle after `aux_gnt`, as a single-cycle pulse per grant.
- **Reset values:** `wait_cnt=0`, `aux_rvalid=0`, `aux_rdata=0`.
- **Outputs while `rst` is high:** `aux_gnt=0`, `cpu_stall=0`, `mem_we=0`.
- **Reset mid-operation:** a pending `aux_rvalid` is dropped, and a waiting request restarts its count at 0 after release.

## Configuration
- `DMEM_ARB_STATS_EN` defined: adds two 16-bit outputs.
  - `stat_stalls` counts `cpu_stall` cycles.
  - `stat_aux_grants` counts `aux_gnt` cycles.
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: these ports and counters do not exist. Arbitration behaviour is identical in both builds.

## Test plan
- **Idle CPU auxiliary read:** RAM[0]=12, CPU idle, `aux_req` read of addr 0 → `aux_gnt` in the same cycle; next cycle `aux_rvalid=1`, `aux_rdata=12`.
- **CPU priority on read:** CPU LDR from addr 0 with no auxiliary traffic → `cpu_rdata=12`, `cpu_stall=0` every cycle.
- **Forced grant under contention:** `MAX_WAIT=4`, CPU requesting every cycle, `aux_req` raised at cycle 0 → `aux_gnt` and `cpu_stall` high only at cycle 4; CPU access completes at cycle 5; `wait_cnt` back to 0.
- **Same-address write race:** forced-grant cycle with auxiliary write 9 to addr 4 and CPU write 7 to addr 4 → RAM[1]=9 after edge 1, then 7 after edge 2.
- **Reset during read return:** `rst` asserted the cycle after an auxiliary read grant → `aux_rvalid=0`, `aux_rdata=0`, `aux_gnt=0`; after release a held `aux_req` with a busy CPU waits a full 4 cycles again.
- **Statistics build:** with `DMEM_ARB_STATS_EN`, run scenario 3 twice → `stat_stalls=2`, `stat_aux_grants=2`.
